// File: rtl/uart_rx_fifo_if.sv
// Bus bundle between the UART receiver and its neighbours: the baud tick and
// rx pad on the input side, the FIFO head with valid/ready plus status pulses
// on the output side.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic                 tick;
    logic                 rx;
    logic [DATA_BITS-1:0] dout;
    logic                 dout_perr;
    logic                 dout_ferr;
    logic                 dout_valid;
    logic                 dout_ready;
    logic                 overrun;
    logic                 break_det;
    logic                 rx_busy;

    // Driver side: tick source, pad and consumer.
    modport master (
        output tick, rx, dout_ready,
        input  dout, dout_perr, dout_ferr, dout_valid, overrun, break_det, rx_busy
    );

    // Receiver side.
    modport slave (
        input  tick, rx, dout_ready,
        output dout, dout_perr, dout_ferr, dout_valid, overrun, break_det, rx_busy
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop rx synchroniser, oversampled start detection with
// glitch rejection, 3-sample majority per bit, optional parity, 1/2 stop bits,
// per-word parity/framing flags and a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_fifo_if.slave bus
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = 4;
    localparam logic [CW-1:0] SMP0      = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] SMP1      = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] SMP2      = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_PUSH, S_WAIT_IDLE
    } state_t;

    typedef struct packed {
        logic                 ferr;
        logic                 perr;
        logic [DATA_BITS-1:0] data;
    } entry_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bitn_q, bitn_d;
    logic [1:0]           smp_q, smp_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 ones_q, ones_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 brk_q, brk_d;
    logic                 push, pop, full, empty;
    logic                 maj, exp_par, in_frame, at_end;

    entry_t               mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_q, rd_q;
    logic [NW-1:0]        fcnt_q;
    entry_t               head;

    // Bring the asynchronous pad into the clk domain; idle level is 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // First two samples are held; the third is the live synchronised value.
    assign maj      = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);
    assign exp_par  = (PARITY == 1) ? ~(^data_q) : (^data_q);
    assign in_frame = (state_q == S_START) || (state_q == S_DATA) ||
                      (state_q == S_PARITY) || (state_q == S_STOP);
    assign at_end   = (cnt_q == LAST_TICK);

    assign full  = (fcnt_q == NW'(FIFO_DEPTH));
    assign empty = (fcnt_q == '0);
    assign pop   = !empty && bus.dout_ready;

    // Receiver state register and frame datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bitn_q  <= '0;
            smp_q   <= '0;
            data_q  <= '0;
            ones_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bitn_q  <= bitn_d;
            smp_q   <= smp_d;
            data_q  <= data_d;
            ones_q  <= ones_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            brk_q   <= brk_d;
        end
    end

    // Next state: tick-paced bit sampling, then a single-clk push decision.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bitn_d  = bitn_q;
        smp_d   = smp_q;
        data_d  = data_q;
        ones_d  = ones_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = 1'b0;
        brk_d   = 1'b0;
        push    = 1'b0;
        if (bus.tick && in_frame) begin
            cnt_d = at_end ? '0 : cnt_q + CW'(1);
            if (cnt_q == SMP0) smp_d[0] = rx_s_q;
            if (cnt_q == SMP1) smp_d[1] = rx_s_q;
        end
        case (state_q)
            S_IDLE: begin
                // The detecting tick is tick 0 of the start bit.
                if (bus.tick && !rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = CW'(1);
                    bitn_d  = '0;
                    ones_d  = 1'b0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            S_START: begin
                if (bus.tick) begin
                    if (cnt_q == SMP2 && maj) state_d = S_IDLE;
                    else if (at_end)          state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bus.tick) begin
                    if (cnt_q == SMP2) begin
                        data_d = {maj, data_q[DATA_BITS-1:1]};
                        ones_d = ones_q | maj;
                    end
                    if (at_end) begin
                        if (bitn_q == LAST_DATA) begin
                            bitn_d  = '0;
                            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bitn_d = bitn_q + BW'(1);
                        end
                    end
                end
            end
            S_PARITY: begin
                if (bus.tick) begin
                    if (cnt_q == SMP2) begin
                        ones_d = ones_q | maj;
                        perr_d = (maj != exp_par);
                    end
                    if (at_end) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bus.tick) begin
                    if (cnt_q == SMP2) begin
                        if (!maj) ferr_d = 1'b1;
                        if (bitn_q == LAST_STOP) state_d = S_PUSH;
                    end
                    if (at_end) bitn_d = bitn_q + BW'(1);
                end
            end
            S_PUSH: begin
                // A pop in the same clk frees the slot even when full.
                push    = !full || pop;
                ovr_d   = !push;
                brk_d   = ferr_q && !ones_q;
                state_d = ferr_q ? S_WAIT_IDLE : S_IDLE;
            end
            S_WAIT_IDLE: begin
                // Hold off until the line recovers so a long break reports once.
                if (bus.tick && rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Receive FIFO storage and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            fcnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= {ferr_q, perr_q, data_q};
                wr_q        <= wr_q + PW'(1);
            end
            if (pop) rd_q <= rd_q + PW'(1);
            fcnt_q <= fcnt_q + NW'(push) - NW'(pop);
        end
    end

    assign head           = mem_q[rd_q];
    assign bus.dout       = head.data;
    assign bus.dout_perr  = head.perr;
    assign bus.dout_ferr  = head.ferr;
    assign bus.dout_valid = !empty;
    assign bus.overrun    = ovr_q;
    assign bus.break_det  = brk_q;
    assign bus.rx_busy    = (state_q != S_IDLE);
endmodule
